// File: rtl/rate_ctrl.sv
// Rate-change controller: arbitrates two requesters and applies a new
// divider select only while the divided clock is low, then masks ticks.
module rate_ctrl #(
    parameter int         SETTLE_CYC  = 4,
    parameter logic [4:0] DEFAULT_SEL = 5'd25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [4:0] sel_a,
    input  logic       req_b,
    input  logic [4:0] sel_b,
    input  logic       tick_in,
    output logic [4:0] sel,
    output logic       ack_a,
    output logic       ack_b,
    output logic       busy,
    output logic       tick_pulse,
    output logic [7:0] tick_count
);

    localparam logic [4:0] MAX_SEL = 5'd25;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        SETTLE
    } state_t;

    state_t     state, state_d;
    logic [4:0] pending;
    logic [3:0] settle_cnt;
    logic       owner_b;
    logic       prio_b;
    logic       tick_q;

    logic       do_grant;
    logic       gnt_b;
    logic       do_apply;
    logic       do_ack;
    logic       owner_req;

    function automatic logic [4:0] clamp(input logic [4:0] v);
        return (v > MAX_SEL) ? MAX_SEL : v;
    endfunction

    assign owner_req  = owner_b ? req_b : req_a;
    assign busy       = (state != IDLE);
    assign tick_pulse = tick_in & ~tick_q & (state != SETTLE) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        do_grant = 1'b0;
        gnt_b    = 1'b0;
        do_apply = 1'b0;
        do_ack   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    do_grant = 1'b1;
                    gnt_b    = req_b & (~req_a | prio_b);
                    state_d  = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (pending == sel) begin
                    do_ack  = 1'b1;
                    state_d = IDLE;
                end else if (!owner_req) begin
                    state_d = IDLE;
                end else if (!tick_in) begin
                    do_apply = 1'b1;
                    do_ack   = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel        <= DEFAULT_SEL;
            pending    <= DEFAULT_SEL;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            tick_count <= 8'd0;
            tick_q     <= 1'b0;
            settle_cnt <= 4'd0;
            owner_b    <= 1'b0;
            prio_b     <= 1'b0;
        end else begin
            tick_q <= tick_in;
            ack_a  <= do_ack & ~owner_b;
            ack_b  <= do_ack & owner_b;
            if (do_grant) begin
                pending <= gnt_b ? clamp(sel_b) : clamp(sel_a);
                owner_b <= gnt_b;
                // Pointer moves only when both contended, so a lone
                // request does not steal the waiting side's turn.
                if (req_a && req_b) begin
                    prio_b <= ~gnt_b;
                end
            end
            if (do_apply) begin
                sel        <= pending;
                tick_count <= 8'd0;
                settle_cnt <= 4'(SETTLE_CYC);
            end else begin
                if (tick_pulse) begin
                    tick_count <= tick_count + 8'd1;
                end
                if (state == SETTLE) begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
            end
        end
    end

endmodule
